alu: RTL and testbench

Registered 32-bit integer ALU for the RV32I execute stage. Decodes the R-type `funct3`/`funct7` fields into one of ten operations: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND. Captures the result and a zero flag in output registers on each clock edge. Feeds the writeback path and the branch-compare logic through `oZero`.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_shifter.sv | 29 ++
 rtl/alu.sv | 71 +++++++
 tb/tb_alu.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and helpers for the RV32I execute-stage ALU.
package alu_pkg;

  localparam int XLEN       = 32;
  localparam int SHAMT_W    = 5;
  localparam int F7_ALT_BIT = 5;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic [XLEN-1:0] bitReverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Five-stage barrel shifter for SLL/SRL/SRA.
// Left shifts reuse the right-shift stages by bit-reversing in and out.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    iData,
  input  logic [SHAMT_W-1:0] iShamt,
  input  logic               iDir,    // 1 = right, 0 = left
  input  logic               iArith,  // sign fill, right shifts only
  output logic [XLEN-1:0]    oData
);

  logic            fill;
  logic [XLEN-1:0] stg [0:SHAMT_W];

  assign fill   = iArith & iDir & iData[XLEN-1];
  assign stg[0] = iDir ? iData : bitReverse(iData);

  genvar s;
  generate
    for (s = 0; s < SHAMT_W; s++) begin : gStage
      localparam int SH = 1 << s;
      assign stg[s+1] = iShamt[s] ? {{SH{fill}}, stg[s][XLEN-1:SH]} : stg[s];
    end
  endgenerate

  assign oData = iDir ? stg[SHAMT_W] : bitReverse(stg[SHAMT_W]);

endmodule

// File: rtl/alu.sv
// Registered RV32I R-type ALU: decode, shared add/sub/compare, shifter,
// logic ops, result mux, zero detect and output registers.
module alu
  import alu_pkg::*;
(
  input  logic            iClk,
  input  logic            iRst,
  input  logic [XLEN-1:0] iDataA,
  input  logic [XLEN-1:0] iDataB,
  input  logic [2:0]      iFunct3,
  input  logic [6:0]      iFunct7,
  output logic [XLEN-1:0] oData,
  output logic            oZero
);

  logic            isAlt;
  logic            useSub;
  logic [XLEN-1:0] opB;
  logic [XLEN:0]   sum;
  logic            ltUnsigned;
  logic            ltSigned;
  logic [XLEN-1:0] shiftOut;
  logic [XLEN-1:0] result;
  logic            unusedFunct7;

  assign isAlt        = iFunct7[F7_ALT_BIT];
  assign unusedFunct7 = ^{iFunct7[6], iFunct7[4:0]};

  // Compares subtract through the same adder as ADD/SUB.
  assign useSub = ((iFunct3 == F3_ADD) & isAlt) | (iFunct3 == F3_SLT) | (iFunct3 == F3_SLTU);
  assign opB    = iDataB ^ {XLEN{useSub}};
  assign sum    = {1'b0, iDataA} + {1'b0, opB} + {{XLEN{1'b0}}, useSub};

  // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
  assign ltUnsigned = ~sum[XLEN];
  assign ltSigned   = (iDataA[XLEN-1] != iDataB[XLEN-1]) ? iDataA[XLEN-1] : sum[XLEN-1];

  alu_shifter uShifter (
    .iData  (iDataA),
    .iShamt (iDataB[SHAMT_W-1:0]),
    .iDir   (iFunct3 == F3_SR),
    .iArith (isAlt),
    .oData  (shiftOut)
  );

  always_comb begin
    result = '0;
    case (iFunct3)
      F3_ADD:  result = sum[XLEN-1:0];
      F3_SLL:  result = shiftOut;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, ltSigned};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, ltUnsigned};
      F3_XOR:  result = iDataA ^ iDataB;
      F3_SR:   result = shiftOut;
      F3_OR:   result = iDataA | iDataB;
      F3_AND:  result = iDataA & iDataB;
      default: result = '0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oData <= '0;
      oZero <= 1'b1;
    end else begin
      oData <= result;
      oZero <= (result == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed cases plus a randomized stream.
module tb_alu;

  logic        iClk;
  logic        iRst;
  logic [31:0] iDataA;
  logic [31:0] iDataB;
  logic [2:0]  iFunct3;
  logic [6:0]  iFunct7;
  logic [31:0] oData;
  logic        oZero;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sbData [$];
  string       sbTag  [$];

  alu dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iDataA  (iDataA),
    .iDataB  (iDataB),
    .iFunct3 (iFunct3),
    .iFunct7 (iFunct7),
    .oData   (oData),
    .oZero   (oZero)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkResult(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got zero=%b data=%h, expected zero=%b data=%h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f3, input logic [6:0] f7);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  return f7[5] ? a - b : a + b;
      3'b001:  return a << sh;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // Drive one cycle of stimulus and queue the result expected one edge later.
  task automatic applyOp(input string tag, input logic rst, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] exp);
    @(negedge iClk);
    iRst    = rst;
    iDataA  = a;
    iDataB  = b;
    iFunct3 = f3;
    iFunct7 = f7;
    sbData.push_back({(exp == 32'h0), exp});
    sbTag.push_back(tag);
  endtask

  task automatic applyModel(input string tag, input logic rst, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] f3, input logic [6:0] f7);
    applyOp(tag, rst, a, b, f3, f7, rst ? 32'h0 : refAlu(a, b, f3, f7));
  endtask

  initial begin
    forever begin
      @(posedge iClk);
      #1;
      if (sbData.size() > 0) checkResult(sbTag.pop_front(), {oZero, oData}, sbData.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b1; iDataA = '0; iDataB = '0; iFunct3 = '0; iFunct7 = '0;

    for (int i = 0; i < 2; i++)
      applyOp("reset", 1'b1, $urandom, $urandom, 3'($urandom), 7'($urandom), 32'h0);

    applyOp("add_10_5",    1'b0, 32'd10, 32'd5, 3'b000, 7'h00, 32'd15);
    applyOp("sub_20_7",    1'b0, 32'd20, 32'd7, 3'b000, 7'h20, 32'd13);
    applyOp("sub_5_5",     1'b0, 32'd5,  32'd5, 3'b000, 7'h20, 32'd0);
    applyOp("sub_0_1",     1'b0, 32'd0,  32'd1, 3'b000, 7'h20, 32'hFFFF_FFFF);
    applyOp("add_wrap",    1'b0, 32'hFFFF_FFFF, 32'd1, 3'b000, 7'h5F, 32'h0);
    applyOp("sll_1_4",     1'b0, 32'd1, 32'd4, 3'b001, 7'h00, 32'h0000_0010);
    applyOp("srl_msb_1",   1'b0, 32'h8000_0000, 32'd1, 3'b101, 7'h00, 32'h4000_0000);
    applyOp("sra_msb_1",   1'b0, 32'h8000_0000, 32'd1, 3'b101, 7'h20, 32'hC000_0000);
    applyOp("sll_b24",     1'b0, 32'd1, 32'h24, 3'b001, 7'h00, 32'h0000_0010);
    applyOp("sll_alt_ign", 1'b0, 32'd3, 32'hFFFF_FFE1, 3'b001, 7'h20, 32'h0000_0006);
    applyOp("sra_31",      1'b0, 32'h8000_0000, 32'd31, 3'b101, 7'h20, 32'hFFFF_FFFF);
    applyOp("srl_31",      1'b0, 32'h8000_0000, 32'd31, 3'b101, 7'h00, 32'h0000_0001);
    applyOp("sltu_5_10",   1'b0, 32'd5, 32'd10, 3'b011, 7'h00, 32'd1);
    applyOp("sltu_10_5",   1'b0, 32'd10, 32'd5, 3'b011, 7'h00, 32'd0);
    applyOp("slt_m1_1",    1'b0, 32'hFFFF_FFFF, 32'd1, 3'b010, 7'h00, 32'd1);
    applyOp("sltu_m1_1",   1'b0, 32'hFFFF_FFFF, 32'd1, 3'b011, 7'h00, 32'd0);
    applyOp("slt_7_7",     1'b0, 32'd7, 32'd7, 3'b010, 7'h00, 32'd0);
    applyOp("slt_max_min", 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 3'b010, 7'h20, 32'd0);
    applyOp("slt_min_max", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b010, 7'h00, 32'd1);
    applyOp("and_c_a",     1'b0, 32'hC, 32'hA, 3'b111, 7'h00, 32'h8);
    applyOp("or_c_a",      1'b0, 32'hC, 32'hA, 3'b110, 7'h00, 32'hE);
    applyOp("xor_c_a",     1'b0, 32'hC, 32'hA, 3'b100, 7'h00, 32'h6);
    applyOp("xor_alt",     1'b0, 32'hC, 32'hA, 3'b100, 7'h20, 32'h6);
    applyOp("add_f7_ign",  1'b0, 32'd10, 32'd5, 3'b000, 7'h5F, 32'd15);

    // Back-to-back stream; the fourth slot carries a reset pulse.
    for (int i = 0; i < 8; i++)
      applyModel((i == 3) ? "b2b_rst" : "b2b", (i == 3), $urandom, $urandom,
                 3'($urandom), 7'($urandom));

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ((i % 4) == 0) b = a;
      if ((i % 7) == 0) a = {a[31], 31'h0};
      applyModel("random", 1'b0, a, b, 3'($urandom), 7'($urandom));
    end

    @(negedge iClk);
    iRst = 1'b0;
    repeat (3) @(posedge iClk);
    #2;
    checkResult("drain", 33'(sbData.size()), 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
